// File: rtl/stats_topk_pkg.sv
// stats_pkg: shared types for the stats_topk ranked vote scanner.
package stats_pkg;

    localparam int COUNT_W_DEFAULT = 32;

    typedef logic [COUNT_W_DEFAULT-1:0] count_t;
    typedef logic signed [31:0]         win_id_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } stats_state_t;

    // Window ID reported in an empty result slot.
    localparam win_id_t NO_MATCH = -32'sd1;

    typedef struct packed {
        win_id_t id;
        count_t  cnt;
        logic    vld;
    } topk_entry_t;

endpackage

// File: rtl/stats_topk_if.sv
// stats_topk_if: request/result bundle between the query controller and stats_topk.
// The ambiguous flag exists only when STATS_TOPK_AMBIGUITY_EN is defined.
interface stats_topk_if
    import stats_pkg::*;
#(
    parameter int MAX_WINDOWS_IN_REFERENCE = 512,
    parameter int COUNT_W                  = 32,
    parameter int TOP_K                    = 4
);
    localparam int VC_W = $clog2(TOP_K + 1);

    logic               clear;
    logic               start;
    logic               ready;
    logic               done;
    logic [COUNT_W-1:0] min_count;
    logic [COUNT_W-1:0] count_bus [MAX_WINDOWS_IN_REFERENCE];
    logic [VC_W-1:0]    valid_count;
    win_id_t            match_id [TOP_K];
    logic [COUNT_W-1:0] match_count [TOP_K];
`ifdef STATS_TOPK_AMBIGUITY_EN
    logic               ambiguous;

    modport master (
        output clear, start, min_count, count_bus,
        input  ready, done, valid_count, match_id, match_count, ambiguous
    );
    modport slave (
        input  clear, start, min_count, count_bus,
        output ready, done, valid_count, match_id, match_count, ambiguous
    );
`else
    modport master (
        output clear, start, min_count, count_bus,
        input  ready, done, valid_count, match_id, match_count
    );
    modport slave (
        input  clear, start, min_count, count_bus,
        output ready, done, valid_count, match_id, match_count
    );
`endif

endinterface

// File: rtl/stats_topk_insert.sv
// stats_topk_insert: combinational insertion of one candidate into a sorted
// TOP_K list (slot 0 best). Equal counts never displace, so earlier (lower ID)
// candidates keep precedence on ties.
module stats_topk_insert
    import stats_pkg::*;
#(
    parameter int COUNT_W = 32,
    parameter int TOP_K   = 4
) (
    input  win_id_t [TOP_K-1:0]              id_in,
    input  logic    [TOP_K-1:0][COUNT_W-1:0] cnt_in,
    input  logic    [TOP_K-1:0]              vld_in,
    input  logic                             cand_vld,
    input  win_id_t                          cand_id,
    input  logic    [COUNT_W-1:0]            cand_cnt,
    output win_id_t [TOP_K-1:0]              id_out,
    output logic    [TOP_K-1:0][COUNT_W-1:0] cnt_out,
    output logic    [TOP_K-1:0]              vld_out
);

    logic [TOP_K-1:0] take;

    // Slots the candidate outranks; monotone because the list is kept sorted.
    always_comb begin
        take = '0;
        for (int i = 0; i < TOP_K; i++) begin
            take[i] = cand_vld && (!vld_in[i] || (cnt_in[i] < cand_cnt));
        end
    end

    // First taken slot receives the candidate, later taken slots shift down by one.
    always_comb begin
        id_out  = id_in;
        cnt_out = cnt_in;
        vld_out = vld_in;
        if (take[0]) begin
            id_out[0]  = cand_id;
            cnt_out[0] = cand_cnt;
            vld_out[0] = 1'b1;
        end
        for (int i = 1; i < TOP_K; i++) begin
            if (take[i]) begin
                if (take[i-1]) begin
                    id_out[i]  = id_in[i-1];
                    cnt_out[i] = cnt_in[i-1];
                    vld_out[i] = vld_in[i-1];
                end else begin
                    id_out[i]  = cand_id;
                    cnt_out[i] = cand_cnt;
                    vld_out[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stats_topk.sv
// stats_topk: multi-beat scan of the per-window vote counts returning the
// TOP_K best window IDs, LANES windows per beat.
// Optional feature: define STATS_TOPK_AMBIGUITY_EN to add the ambiguous flag
// (top two results tied).
module stats_topk
    import stats_pkg::*;
#(
    parameter int MAX_WINDOWS_IN_REFERENCE = 512,
    parameter int COUNT_W                  = 32,
    parameter int TOP_K                    = 4,
    parameter int LANES                    = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    stats_topk_if.slave   bus
);

    localparam int MAXW  = MAX_WINDOWS_IN_REFERENCE;
    localparam int VC_W  = $clog2(TOP_K + 1);
    localparam int PTR_W = $clog2(MAXW + LANES + 1);
    localparam int IDX_W = (MAXW > 1) ? $clog2(MAXW) : 1;

    stats_state_t state, state_next;

    logic [PTR_W-1:0]   ptr;
    logic [COUNT_W-1:0] min_lat;
    logic               last_beat;

    // Working list accumulated during SCAN.
    win_id_t [TOP_K-1:0]              list_id;
    logic    [TOP_K-1:0][COUNT_W-1:0] list_cnt;
    logic    [TOP_K-1:0]              list_vld;

    // Published results, held until the next DONE or clear.
    win_id_t [TOP_K-1:0]              res_id;
    logic    [TOP_K-1:0][COUNT_W-1:0] res_cnt;
    logic    [VC_W-1:0]               res_vc;

    // Insertion chain: stage 0 is the working list, stage LANES the beat result.
    win_id_t [TOP_K-1:0]              chain_id  [LANES+1];
    logic    [TOP_K-1:0][COUNT_W-1:0] chain_cnt [LANES+1];
    logic    [TOP_K-1:0]              chain_vld [LANES+1];

    logic [31:0]        lane_idx [LANES];
    win_id_t            cand_id  [LANES];
    logic [COUNT_W-1:0] cand_cnt [LANES];
    logic [LANES-1:0]   cand_vld;

    function automatic logic [VC_W-1:0] count_filled(input logic [TOP_K-1:0] v);
        logic [VC_W-1:0] n;
        n = '0;
        for (int i = 0; i < TOP_K; i++) begin
            n = n + VC_W'(v[i]);
        end
        return n;
    endfunction

    assign last_beat = (32'(ptr) + 32'(LANES)) >= 32'(MAXW);

    // Fetch this beat's lanes; indices past the last window read as count 0 and never qualify.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = 32'(ptr) + 32'(l);
            cand_id[l]  = win_id_t'(lane_idx[l]);
            cand_cnt[l] = '0;
            if (lane_idx[l] < 32'(MAXW)) begin
                cand_cnt[l] = bus.count_bus[lane_idx[l][IDX_W-1:0]];
            end
            cand_vld[l] = (cand_cnt[l] != '0) && (cand_cnt[l] >= min_lat);
        end
    end

    assign chain_id[0]  = list_id;
    assign chain_cnt[0] = list_cnt;
    assign chain_vld[0] = list_vld;

    // Lanes are inserted in ascending window order so ties favour the lower ID.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        stats_topk_insert #(
            .COUNT_W (COUNT_W),
            .TOP_K   (TOP_K)
        ) u_insert (
            .id_in    (chain_id[l]),
            .cnt_in   (chain_cnt[l]),
            .vld_in   (chain_vld[l]),
            .cand_vld (cand_vld[l]),
            .cand_id  (cand_id[l]),
            .cand_cnt (cand_cnt[l]),
            .id_out   (chain_id[l+1]),
            .cnt_out  (chain_cnt[l+1]),
            .vld_out  (chain_vld[l+1])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state and handshake outputs; clear overrides everything including start.
    always_comb begin
        state_next = state;
        bus.ready  = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) state_next = SCAN;
            end
            SCAN: begin
                if (last_beat) state_next = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (bus.clear) state_next = IDLE;
    end

    // Scan pointer, working list and published results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr      <= '0;
            min_lat  <= '0;
            list_id  <= {TOP_K{NO_MATCH}};
            list_cnt <= '0;
            list_vld <= '0;
            res_id   <= {TOP_K{NO_MATCH}};
            res_cnt  <= '0;
            res_vc   <= '0;
        end else if (bus.clear) begin
            ptr      <= '0;
            min_lat  <= '0;
            list_id  <= {TOP_K{NO_MATCH}};
            list_cnt <= '0;
            list_vld <= '0;
            res_id   <= {TOP_K{NO_MATCH}};
            res_cnt  <= '0;
            res_vc   <= '0;
        end else if (state == IDLE && bus.start) begin
            ptr      <= '0;
            min_lat  <= bus.min_count;
            list_id  <= {TOP_K{NO_MATCH}};
            list_cnt <= '0;
            list_vld <= '0;
        end else if (state == SCAN) begin
            ptr      <= ptr + PTR_W'(LANES);
            list_id  <= chain_id[LANES];
            list_cnt <= chain_cnt[LANES];
            list_vld <= chain_vld[LANES];
            if (last_beat) begin
                res_id  <= chain_id[LANES];
                res_cnt <= chain_cnt[LANES];
                res_vc  <= count_filled(chain_vld[LANES]);
            end
        end
    end

`ifdef STATS_TOPK_AMBIGUITY_EN
    logic res_amb;

    // Top-two tie flag, published with the results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                      res_amb <= 1'b0;
        else if (bus.clear)                res_amb <= 1'b0;
        else if (state == SCAN && last_beat)
            res_amb <= chain_vld[LANES][1] && (chain_cnt[LANES][1] == chain_cnt[LANES][0]);
    end

    assign bus.ambiguous = res_amb;
`endif

    // Present the held results on the unpacked result ports.
    always_comb begin
        for (int i = 0; i < TOP_K; i++) begin
            bus.match_id[i]    = res_id[i];
            bus.match_count[i] = res_cnt[i];
        end
    end

    assign bus.valid_count = res_vc;

endmodule
